// File: rtl/fp8_dot_acc.sv
// fp8_dot_acc: registered multi-lane FP8 dot-product accumulator.
//   Each lane multiplies an FP8 pair (E4M3 or E5M2) into FP16 with RNE
//   rounding. It then adds the product into an FP16 accumulator, which is
//   seeded from in_c on the first beat of a group. One FP16 result per lane
//   is emitted when a group closes. A group closes after ACC_LEN beats or on
//   a beat with in_last.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_last               closes the current group on this beat
//   fmt_a, fmt_b          1: E4M3 (bias 7), 0: E5M2 (bias 15)
//   in_a, in_b            FP8 operands, lane i at [8i+7:8i]
//   in_c                  FP16 seed, lane i at [16i+15:16i], first beat only
//   out_valid/out_ready   result handshake; out_valid held until out_ready
//   out_data              FP16 results, lane i at [16i+15:16i]
module fp8_dot_acc #(
  parameter int LANES   = 2,
  parameter int ACC_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  fmt_a,
  input  logic                  fmt_b,
  input  logic [8*LANES-1:0]    in_a,
  input  logic [8*LANES-1:0]    in_b,
  input  logic [16*LANES-1:0]   in_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_data
);

  localparam int CW = $clog2(ACC_LEN + 1);

  // Round mant * 2^e to FP16 with round-to-nearest-even. The LSB exponent of
  // the result is the larger of (msb exponent - 10) and -24 (the subnormal
  // LSB); the encoding is then ((lsb + 24) << 10) + q, which absorbs both the
  // mantissa carry-out and the subnormal-to-normal transition.
  function automatic logic [15:0] rne16(input logic sign, input logic [47:0] mant, input int e);
    int          p, ex, lsb, sh;
    longint      total;
    logic [47:0] q, gmask;
    logic        g, st;
    logic [15:0] res;
    p = 0;
    for (int i = 0; i < 48; i++) if (mant[i]) p = i;
    ex  = p + e;
    lsb = (ex - 10 > -24) ? ex - 10 : -24;
    sh  = lsb - e;
    if (sh <= 0) begin
      q  = mant << (-sh);
      g  = 1'b0;
      st = 1'b0;
    end else begin
      q     = mant >> sh;
      gmask = 48'd1 << (sh - 1);
      g     = |(mant & gmask);
      st    = |(mant & (gmask - 48'd1));
    end
    if (g && (st || q[0])) q = q + 48'd1;
    total = longint'(lsb + 24) * 64'sd1024 + longint'(q);
    if (mant == 48'd0)            res = {sign, 15'd0};
    else if (total >= 64'sd31744) res = {sign, 15'h7C00};
    else                          res = {sign, total[14:0]};
    return res;
  endfunction

  // FP8 decode: value = sig * 2^(ex - 3), sig carries the hidden bit.
  function automatic void dec8(input logic [7:0] x, input logic e4m3,
                               output logic nan, output logic inf,
                               output logic [3:0] sig, output int ex);
    logic [4:0] e;
    if (e4m3) begin
      e   = {1'b0, x[6:3]};
      nan = (e == 5'd15) && (x[2:0] != 3'd0);
      inf = (e == 5'd15) && (x[2:0] == 3'd0);
      sig = {e != 5'd0, x[2:0]};
      ex  = int'((e == 5'd0) ? 5'd1 : e) - 7;
    end else begin
      e   = x[6:2];
      nan = (e == 5'd31) && (x[1:0] != 2'd0);
      inf = (e == 5'd31) && (x[1:0] == 2'd0);
      sig = {e != 5'd0, x[1:0], 1'b0};
      ex  = int'((e == 5'd0) ? 5'd1 : e) - 15;
    end
  endfunction

  function automatic logic [15:0] fp8_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic fa, input logic fb);
    logic       na, ia, nb, ib, s;
    logic [3:0] sa, sb;
    int         ea, eb;
    logic [7:0] pm;
    logic [15:0] res;
    dec8(a, fa, na, ia, sa, ea);
    dec8(b, fb, nb, ib, sb, eb);
    s  = a[7] ^ b[7];
    pm = 8'(sa) * 8'(sb);
    if (na || nb)
      res = 16'h7FFF;
    else if (ia || ib)
      res = ((ia && sb == 4'd0) || (ib && sa == 4'd0)) ? 16'h7FFF : {s, 15'h7C00};
    else
      res = rne16(s, {40'd0, pm}, ea + eb - 6);
    return res;
  endfunction

  // FP16 decode to an exact integer magnitude in units of 2^-24.
  function automatic void dec16(input logic [15:0] x, output logic nan, output logic inf,
                                output logic [40:0] mag);
    logic [4:0] e;
    e   = x[14:10];
    nan = (e == 5'd31) && (x[9:0] != 10'd0);
    inf = (e == 5'd31) && (x[9:0] == 10'd0);
    mag = {30'd0, (e != 5'd0), x[9:0]} << ((e == 5'd0) ? 5'd0 : (e - 5'd1));
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic        nx, ix, ny, iy, s;
    logic [40:0] mx, my, mag;
    logic [15:0] res;
    dec16(x, nx, ix, mx);
    dec16(y, ny, iy, my);
    if (x[15] == y[15]) begin
      mag = mx + my;
      s   = x[15];
    end else if (mx >= my) begin
      mag = mx - my;
      s   = x[15];
    end else begin
      mag = my - mx;
      s   = y[15];
    end
    // Exact cancellation of opposite signs yields +0.
    if (mag == 41'd0 && x[15] != y[15]) s = 1'b0;
    if (nx || ny)      res = 16'h7FFF;
    else if (ix && iy) res = (x[15] == y[15]) ? x : 16'h7FFF;
    else if (ix)       res = x;
    else if (iy)       res = y;
    else               res = rne16(s, {7'd0, mag}, -24);
    return res;
  endfunction

  // Handshake: a beat transfers when in_valid & in_ready; a result transfers
  // when out_valid & out_ready. The whole pipeline advances only when the
  // output register is free or being drained this cycle (adv), and in_ready
  // is exactly adv, so an accepted beat can never be stalled.
  logic          adv, accept, last_now;
  logic [CW-1:0] cnt;
  logic          m_valid, m_first, m_last;
  logic [15:0]   m_p    [LANES];
  logic [15:0]   m_seed [LANES];
  logic [15:0]   acc    [LANES];
  logic [15:0]   p_next [LANES];
  logic [15:0]   s_next [LANES];

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = rst_n && adv;
  assign accept   = in_valid && in_ready;
  assign last_now = in_last || (cnt == CW'(ACC_LEN - 1));

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      p_next[i] = fp8_mul(in_a[8*i +: 8], in_b[8*i +: 8], fmt_a, fmt_b);
      s_next[i] = fp16_add(m_first ? m_seed[i] : acc[i], m_p[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      m_valid   <= 1'b0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < LANES; i++) begin
        m_p[i]    <= 16'd0;
        m_seed[i] <= 16'd0;
        acc[i]    <= 16'd0;
      end
    end else if (adv) begin
      // Stage M: register products and group bookkeeping.
      m_valid <= accept;
      if (accept) begin
        m_first <= (cnt == '0);
        m_last  <= last_now;
        cnt     <= last_now ? '0 : cnt + CW'(1);
        for (int i = 0; i < LANES; i++) begin
          m_p[i]    <= p_next[i];
          m_seed[i] <= in_c[16*i +: 16];
        end
      end
      // Stage A: accumulate, or publish on the closing beat.
      out_valid <= m_valid && m_last;
      if (m_valid) begin
        for (int i = 0; i < LANES; i++) begin
          if (m_last) out_data[16*i +: 16] <= s_next[i];
          else        acc[i]               <= s_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fp8_dot_acc.sv
// tb_fp8_dot_acc: directed bench for fp8_dot_acc with LANES=2, ACC_LEN=4.
//   Lane 0 sits in the low half of every packed vector, lane 1 in the high half.
module tb_fp8_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, fmt;
  logic [15:0] in_a, in_b;
  logic [31:0] in_c;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fp8_dot_acc #(.LANES(2), .ACC_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt_a(fmt), .fmt_b(fmt),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transferred result is compared with the next expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && out_valid && out_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
      check("sb_result", out_data, e);
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] c, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [31:0] hold;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; fmt = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Full-length group: lane0 1+4*2=9, lane1 0+4*4=16; latency check.
    exp_q.push_back(32'h4C00_4880);
    for (int i = 0; i < 4; i++) send(16'h4038, 16'h4040, 32'h0000_3C00, 1'b0);
    check("t1_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_lat_valid", 32'(out_valid), 32'd1);
    idle(3);

    // NaN sticky through a 2-beat group; lane1 1*1+1*1.
    exp_q.push_back(32'h4000_7FFF);
    send(16'h387F, 16'h3838, 32'h0000_0000, 1'b0);
    send(16'h3838, 16'h3838, 32'h0000_0000, 1'b1);
    // Inf*0 on lane0; (+Inf) + (-Inf) on lane1.
    exp_q.push_back(32'h7FFF_7FFF);
    send(16'hF878, 16'h3800, 32'h7C00_0000, 1'b1);
    idle(3);
    // E5M2: overflow to +Inf on lane0; 1.0 + (1*-2) = -1 on lane1.
    fmt = 1'b0;
    exp_q.push_back(32'hBC00_7C00);
    send(16'h3C7B, 16'hC07B, 32'h3C00_0000, 1'b1);
    // E5M2 product underflow: +0 on lane0, -0 + -0 stays -0 on lane1.
    exp_q.push_back(32'h8000_0000);
    send(16'h0101, 16'h8101, 32'h8000_0000, 1'b1);
    idle(3);

    // Subnormal product; exact cancellation gives +0.
    fmt = 1'b1;
    exp_q.push_back(32'h0000_0040);
    send(16'h3801, 16'h4001, 32'hC000_0000, 1'b1);
    // Ties-to-even on the sum: 1+2^-11 -> 1.0, (1+2^-10)+2^-11 -> 1+2^-9.
    exp_q.push_back(32'h3C02_3C00);
    send(16'h0808, 16'h1010, 32'h3C01_3C00, 1'b1);
    idle(3);

    // Backpressure: three 1-beat groups streamed while out_ready is low.
    out_ready = 1'b0;
    exp_q.push_back(32'h4500_4000);
    exp_q.push_back(32'h4000_3C00);
    exp_q.push_back(32'h4600_4400);
    fork
      begin
        send(16'h4038, 16'h4040, 32'h3C00_0000, 1'b1);
        send(16'h3838, 16'h3838, 32'h3C00_0000, 1'b1);
        send(16'h4840, 16'h3840, 32'h4000_0000, 1'b1);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("t4_pending", 32'(out_valid), 32'd1);
        hold = out_data;
        repeat (4) begin
          check("t4_in_ready_low", 32'(in_ready), 32'd0);
          check("t4_hold_data", out_data, hold);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("t4_back_to_back", 32'(out_valid), 32'd1);
        end
      end
    join
    idle(3);

    // Early close on beat 2, then a full group seeded with 4.0.
    exp_q.push_back(32'h4600_4400);
    send(16'h4038, 16'h4040, 32'h0000_3C00, 1'b0);
    send(16'h4038, 16'h3838, 32'h0000_0000, 1'b1);
    exp_q.push_back(32'h4A00_4800);
    for (int i = 0; i < 4; i++) send(16'h3838, 16'h4038, 32'h4400_4400, 1'b0);
    idle(4);

    // Reset mid-group: two beats then reset; the next group is clean.
    send(16'h4040, 16'h4040, 32'h3C00_3C00, 1'b0);
    send(16'h4040, 16'h4040, 32'h3C00_3C00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_data", out_data, 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'h4880_4400);
    for (int i = 0; i < 4; i++) send(16'h3838, 16'h4038, 32'h3C00_0000, 1'b0);
    idle(6);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
